vram_scanout: RTL

- Display-side reader of the VRAM frame buffer that the SPU writes (9-bit pixel data, 16-bit address).
- Generates 640x480@60 raster timing and fetches 160x120 buffer pixels, each replicated 4x4.
- Drives RGB333 plus syncs to the DAC/connector.
- Flags vertical blanking so the SPU can schedule writes; issues at most one VRAM read per 4 pixels, leaving port bandwidth free.

---
 rtl/vram_scanout.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vram_scanout.sv
// Frame-buffer scanout: 640x480@60 raster timing, 4x4 pixel replication from a 160x120 VRAM image.
// Counter state reaches the pins two cycles later; vblank status is aligned with the counters themselves.
module vram_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W        = H_ACTIVE >> SCALE_SHIFT,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [8:0]  rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [8:0]  rgb,
  output logic        vblank,
  output logic        vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic [15:0]   r_row_base;
  logic          r_rd_en;
  logic [15:0]   r_rd_addr;
  logic          r_de1, r_de2;
  logic          r_hs1, r_hs2;
  logic          r_vs1, r_vs2;
  logic          r_first1, r_first2;
  logic [8:0]    r_pix_hold;
  logic          r_vblank;
  logic          r_vblank_start;

  logic          w_h_wrap;
  logic          w_v_wrap;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;
  logic          w_active;
  logic          w_hs_raw;
  logic          w_vs_raw;
  logic          w_fetch;
  logic [15:0]   w_fetch_addr;
  logic          w_row_step;

  assign w_h_wrap = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_wrap = (r_v_cnt == VW'(V_TOTAL - 1));
  assign w_h_next = w_h_wrap ? '0 : r_h_cnt + HW'(1);
  assign w_v_next = w_h_wrap ? (w_v_wrap ? '0 : r_v_cnt + VW'(1)) : r_v_cnt;

  assign w_active = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
  assign w_hs_raw = (r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                    (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_raw = (r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                    (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC));

  // One fetch per replication group; the row base advances every 2^SCALE_SHIFT lines.
  assign w_fetch      = w_active && (r_h_cnt[SCALE_SHIFT-1:0] == '0);
  assign w_fetch_addr = r_row_base + 16'(r_h_cnt >> SCALE_SHIFT);
  assign w_row_step   = (w_v_next[SCALE_SHIFT-1:0] == '0) && (w_v_next < VW'(V_ACTIVE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_row_base <= '0;
    end else begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
      if (w_h_wrap) begin
        if (w_v_wrap)
          r_row_base <= '0;
        else if (w_row_step)
          r_row_base <= r_row_base + 16'(FB_W);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_en <= w_fetch;
      if (w_fetch)
        r_rd_addr <= w_fetch_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de1      <= 1'b0;
      r_de2      <= 1'b0;
      r_hs1      <= 1'b0;
      r_hs2      <= 1'b0;
      r_vs1      <= 1'b0;
      r_vs2      <= 1'b0;
      r_first1   <= 1'b0;
      r_first2   <= 1'b0;
      r_pix_hold <= '0;
    end else begin
      r_de1    <= w_active;
      r_de2    <= r_de1;
      r_hs1    <= w_hs_raw;
      r_hs2    <= r_hs1;
      r_vs1    <= w_vs_raw;
      r_vs2    <= r_vs1;
      r_first1 <= w_fetch;
      r_first2 <= r_first1;
      if (r_first2)
        r_pix_hold <= rd_data;
    end
  end

  // Computed from the next counter values so the flags line up with the counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblank       <= 1'b0;
      r_vblank_start <= 1'b0;
    end else begin
      r_vblank       <= (w_v_next >= VW'(V_ACTIVE));
      r_vblank_start <= (w_h_next == '0) && (w_v_next == VW'(V_ACTIVE));
    end
  end

  // The first pixel of a group shows the word straight off the read port, so there is no bubble.
  assign rgb          = r_de2 ? (r_first2 ? rd_data : r_pix_hold) : 9'd0;
  assign de           = r_de2;
  assign hsync        = r_hs2 ? SYNC_POL : ~SYNC_POL;
  assign vsync        = r_vs2 ? SYNC_POL : ~SYNC_POL;
  assign rd_en        = r_rd_en;
  assign rd_addr      = r_rd_addr;
  assign vblank       = r_vblank;
  assign vblank_start = r_vblank_start;

endmodule
